calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Multi-cycle arithmetic sequencer for the 6-digit signed-magnitude calculator.
- Sits between the state controller, which supplies operands, sign and the enable pulse, and the display mux and digit separator, which consume the result, sign and error.
- Runs add/sub in a single execute cycle; runs multiply (shift-add) and divide (restoring) as WIDTH-cycle iterations.
- Range-checks every result against the 6-digit display limit.

Parameters:
- WIDTH, 40: operand/result magnitude width in bits.
- MAX_VAL, 999999: largest displayable magnitude; anything larger is an error.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle start pulse.
- i_abort  in  1  one-cycle abort pulse, driven by the reset-button pulse.
- i_func  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- i_s1  in  WIDTH  operand A magnitude.
- i_s1_sign  in  1  operand A sign, 1 = negative.
- i_s2  in  WIDTH  operand B magnitude, always non-negative.
- o_busy  out  1  high from the cycle after an accepted start until DONE.
- o_done  out  1  one-cycle pulse when the result is valid.
- o_result  out  WIDTH  result magnitude, registered.
- o_sign  out  1  result sign, registered.
- o_err  out  1  overflow or divide-by-zero, registered.

Behaviour:
- Reset (i_rst_n=0 at a clk edge):
  - state=IDLE, counter=0, all internal registers 0.
  - o_busy=0, o_done=0, o_result=0, o_sign=0, o_err=0.
  - Reset takes priority over every other input and applies mid-operation too.
- States: IDLE, LOAD, ADDSUB, MUL_ITER, DIV_ITER, CHECK, DONE.
- IDLE:
  - i_start=1 latches i_func, i_s1, i_s1_sign and i_s2, then goes to LOAD.
  - i_start is ignored in every other state; there is no queueing.
- LOAD:
  - func 0x goes to ADDSUB.
  - func 10 goes to MUL_ITER with accumulator=0 and counter=0.
  - func 11 with s2=0 sets the err flag and goes straight to CHECK.
  - func 11 with s2≠0 goes to DIV_ITER with remainder=0 and counter=0.
- ADDSUB (one cycle), signed-magnitude rules:
  - Sub: invert B's sign (B is positive, so it becomes negative), then add.
  - Signs equal: magnitude = A+B computed at WIDTH+1 bits; sign = common sign.
  - Signs differ: magnitude = larger − smaller; sign = sign of the larger. Equal magnitudes give 0.
- MUL_ITER:
  - One multiplier bit per cycle, LSB first, over WIDTH cycles.
  - Accumulator is 2*WIDTH bits. Leave for CHECK when counter == WIDTH−1.
  - Sign = A.sign.
- DIV_ITER:
  - Restoring division, one quotient bit per cycle, MSB first, over WIDTH cycles.
  - Quotient truncates toward zero; the remainder is discarded.
  - Sign = A.sign.
- CHECK:
  - err=1 if the divide-by-zero flag is set or the magnitude > MAX_VAL. For mul, any nonzero upper WIDTH bits also counts as > MAX_VAL.
  - If err: result=0, sign=0.
  - Zero magnitude always forces sign=0 (no negative zero).
  - Go to DONE.
- DONE:
  - o_result, o_sign and o_err are updated on entry.
  - o_done=1 for exactly this one cycle; o_busy=0 in this cycle.
  - Next state is IDLE.
- Latency, from the i_start sample edge to the o_done cycle:
  - add/sub: 4 cycles.
  - mul/div: WIDTH+3 cycles.
  - divide-by-zero: 3 cycles.
- Outputs hold their values until the next DONE, an abort, or reset.
- i_abort=1 in any state (reset inactive):
  - Next state IDLE; o_result, o_sign and o_err clear to 0.
  - No o_done pulse is issued.
  - If i_abort and i_start arrive in the same cycle, abort wins and the start is dropped.
- o_busy=1 exactly in LOAD, ADDSUB, MUL_ITER, DIV_ITER and CHECK.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum;
  - the function-code constants FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV;
  - the default MAX_VAL constant.
- One natural sub-module, calc_signmag_addsub: combinational signed-magnitude add/sub returning magnitude and sign.
- The mul/div iteration stays in the sequencer, because it shares the counter and operand registers.

Test Plan:
- add: s1=123 (+), s2=456 -> o_done 4 cycles after start; result 579, sign 0, err 0.
- sub: s1=100 (+), s2=250 -> result 150, sign 1. Separately, s1=5 (−), s2=5 with func=add -> result 0, sign 0.
- mul: s1=999 (−), s2=1000 -> o_done at WIDTH+3=43 cycles; result 999000, sign 1. Separately, s1=1000, s2=1000 -> err 1, result 0.
- div: s1=1000 (+), s2=7 -> result 142, err 0. Separately, s2=0 -> o_done at 3 cycles, err 1, result 0.
- Second i_start during MUL_ITER -> ignored: no change to the latched operands, a single o_done.
- i_abort in cycle 10 of DIV_ITER -> IDLE next cycle, outputs 0, no o_done. Separately, i_rst_n=0 mid-operation -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator arithmetic sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADDSUB,
        ST_MUL_ITER,
        ST_DIV_ITER,
        ST_CHECK,
        ST_DONE
    } calc_state_e;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    localparam int unsigned DEF_MAX_VAL = 999999;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Operand/command bus between the state controller and the arithmetic sequencer.
interface calc_op_sequencer_if #(
    parameter int WIDTH = 40
);
    logic             i_start;
    logic             i_abort;
    logic [1:0]       i_func;
    logic [WIDTH-1:0] i_s1;
    logic             i_s1_sign;
    logic [WIDTH-1:0] i_s2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_sign;
    logic             o_err;

    modport master (
        output i_start, i_abort, i_func, i_s1, i_s1_sign, i_s2,
        input  o_busy, o_done, o_result, o_sign, o_err
    );

    modport slave (
        input  i_start, i_abort, i_func, i_s1, i_s1_sign, i_s2,
        output o_busy, o_done, o_result, o_sign, o_err
    );
endinterface

// File: rtl/calc_signmag_addsub.sv
// Combinational signed-magnitude adder/subtractor; magnitude is one bit wider
// than the operands so a carry out shows up as an over-range result.
module calc_signmag_addsub #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_a_sign,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_b_sign,
    input  logic             i_sub,
    output logic [WIDTH:0]   o_mag,
    output logic             o_sign
);
    logic w_b_sign;

    assign w_b_sign = i_b_sign ^ i_sub;

    always_comb begin
        o_mag  = '0;
        o_sign = 1'b0;
        if (i_a_sign == w_b_sign) begin
            o_mag  = {1'b0, i_a} + {1'b0, i_b};
            o_sign = i_a_sign;
        end else if (i_a >= i_b) begin
            o_mag  = {1'b0, i_a - i_b};
            o_sign = i_a_sign;
        end else begin
            o_mag  = {1'b0, i_b - i_a};
            o_sign = w_b_sign;
        end
    end
endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle arithmetic sequencer: single-cycle add/sub, shift-add multiply,
// restoring divide, then a range check against the display limit.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int          WIDTH   = 40,
    parameter int unsigned MAX_VAL = DEF_MAX_VAL,
    parameter int          CNT_W   = 6
) (
    input logic           i_clk,
    input logic           i_rst_n,
    calc_op_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

    calc_state_e        r_state, w_state_nxt;
    logic [1:0]         r_func;
    logic [WIDTH-1:0]   r_a, r_b, r_rem;
    logic               r_a_sign, r_rsign, r_dz;
    logic [2*WIDTH-1:0] r_acc, r_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_sign, r_err;

    logic [WIDTH:0]     w_as_mag;
    logic               w_as_sign;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_diff;
    logic               w_rem_ge;
    logic               w_err, w_zero;

    calc_signmag_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a      (r_a),
        .i_a_sign (r_a_sign),
        .i_b      (r_b),
        .i_b_sign (1'b0),
        .i_sub    (r_func == FUNC_SUB),
        .o_mag    (w_as_mag),
        .o_sign   (w_as_sign)
    );

    // Restoring divide step: dividend bits leave r_sh MSB first.
    assign w_rem_sh   = {r_rem, r_sh[WIDTH-1]};
    assign w_rem_ge   = w_rem_sh >= {1'b0, r_b};
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;

    // Anything in the upper half (mul product or add carry) is over range.
    assign w_err  = r_dz | (|r_acc[2*WIDTH-1:WIDTH]) | (r_acc[WIDTH-1:0] > LP_MAX);
    assign w_zero = (r_acc[WIDTH-1:0] == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (bus.i_start) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                case (r_func)
                    FUNC_MUL: w_state_nxt = ST_MUL_ITER;
                    FUNC_DIV: w_state_nxt = (r_b == '0) ? ST_CHECK : ST_DIV_ITER;
                    default:  w_state_nxt = ST_ADDSUB;
                endcase
            end
            ST_ADDSUB:   w_state_nxt = ST_CHECK;
            ST_MUL_ITER: if (r_cnt == LP_LAST) w_state_nxt = ST_CHECK;
            ST_DIV_ITER: if (r_cnt == LP_LAST) w_state_nxt = ST_CHECK;
            ST_CHECK:    w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        if (bus.i_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_func   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_sign <= 1'b0;
            r_rsign  <= 1'b0;
            r_dz     <= 1'b0;
            r_acc    <= '0;
            r_sh     <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.i_abort) begin
                r_result <= '0;
                r_sign   <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.i_start) begin
                            r_func   <= bus.i_func;
                            r_a      <= bus.i_s1;
                            r_a_sign <= bus.i_s1_sign;
                            r_b      <= bus.i_s2;
                        end
                    end
                    ST_LOAD: begin
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_sh    <= {{WIDTH{1'b0}}, r_a};
                        r_rsign <= r_a_sign;
                        r_dz    <= (r_func == FUNC_DIV) && (r_b == '0);
                    end
                    ST_ADDSUB: begin
                        r_acc   <= {{(WIDTH-1){1'b0}}, w_as_mag};
                        r_rsign <= w_as_sign;
                    end
                    ST_MUL_ITER: begin
                        r_acc <= r_acc + (r_b[0] ? r_sh : '0);
                        r_sh  <= r_sh << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_DIV_ITER: begin
                        r_acc <= {r_acc[2*WIDTH-2:0], w_rem_ge};
                        r_rem <= w_rem_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
                        r_sh  <= r_sh << 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_CHECK: begin
                        r_result <= w_err ? '0 : r_acc[WIDTH-1:0];
                        r_sign   <= (w_err || w_zero) ? 1'b0 : r_rsign;
                        r_err    <= w_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_busy   = (r_state == ST_LOAD) || (r_state == ST_ADDSUB) ||
                          (r_state == ST_MUL_ITER) || (r_state == ST_DIV_ITER) ||
                          (r_state == ST_CHECK);
    assign bus.o_done   = (r_state == ST_DONE);
    assign bus.o_result = r_result;
    assign bus.o_sign   = r_sign;
    assign bus.o_err    = r_err;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed operations push expected
// results; a negedge monitor pops and compares on every o_done.
module tb_calc_op_sequencer;
    localparam int W = 40;

    typedef struct {
        logic [W-1:0] res;
        logic         sgn;
        logic         err;
        int           lat;
        int           st;
        string        nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    calc_op_sequencer_if #(.WIDTH(W)) bus ();

    calc_op_sequencer #(.WIDTH(W), .MAX_VAL(999999), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every o_done must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.o_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.nm, "_result"}, 64'(bus.o_result), 64'(e.res));
                chk({e.nm, "_sign"}, 64'(bus.o_sign), 64'(e.sgn));
                chk({e.nm, "_err"}, 64'(bus.o_err), 64'(e.err));
                chk({e.nm, "_latency"}, 64'(cyc - e.st + 1), 64'(e.lat));
            end
        end
    end

    task automatic drive_start(input logic [1:0] f, input logic [W-1:0] a,
                               input logic as, input logic [W-1:0] b);
        bus.i_func    = f;
        bus.i_s1      = a;
        bus.i_s1_sign = as;
        bus.i_s2      = b;
        bus.i_start   = 1'b1;
    endtask

    task automatic op(input string nm, input logic [1:0] f, input logic [W-1:0] a,
                      input logic as, input logic [W-1:0] b, input logic [W-1:0] er,
                      input logic es, input logic ee, input int lat);
        exp_t e;
        @(negedge clk);
        drive_start(f, a, as, b);
        e.res = er; e.sgn = es; e.err = ee; e.lat = lat; e.st = cyc + 1; e.nm = nm;
        q.push_back(e);
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({nm, "_done"}, 64'(bus.o_done), 64'd0);
        chk({nm, "_result"}, 64'(bus.o_result), 64'd0);
        chk({nm, "_sign"}, 64'(bus.o_sign), 64'd0);
        chk({nm, "_err"}, 64'(bus.o_err), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_func = 2'b00;
        bus.i_s1 = '0; bus.i_s1_sign = 1'b0; bus.i_s2 = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        op("add_123_456", 2'b00, 40'd123, 1'b0, 40'd456, 40'd579, 1'b0, 1'b0, 4);       drain();
        op("sub_100_250", 2'b01, 40'd100, 1'b0, 40'd250, 40'd150, 1'b1, 1'b0, 4);       drain();
        op("add_m5_5",    2'b00, 40'd5,   1'b1, 40'd5,   40'd0,   1'b0, 1'b0, 4);       drain();
        op("add_at_max",  2'b00, 40'd999998, 1'b0, 40'd1, 40'd999999, 1'b0, 1'b0, 4);   drain();
        op("add_over",    2'b00, 40'd999999, 1'b0, 40'd1, 40'd0, 1'b0, 1'b1, 4);        drain();
        op("mul_m999_1000", 2'b10, 40'd999, 1'b1, 40'd1000, 40'd999000, 1'b1, 1'b0, 43); drain();
        op("mul_over",    2'b10, 40'd1000, 1'b0, 40'd1000, 40'd0, 1'b0, 1'b1, 43);      drain();
        op("div_1000_7",  2'b11, 40'd1000, 1'b0, 40'd7, 40'd142, 1'b0, 1'b0, 43);       drain();
        op("div_m1000_7", 2'b11, 40'd1000, 1'b1, 40'd7, 40'd142, 1'b1, 1'b0, 43);       drain();
        op("div_m1_1000", 2'b11, 40'd1,    1'b1, 40'd1000, 40'd0, 1'b0, 1'b0, 43);      drain();
        op("div_by_zero", 2'b11, 40'd55,   1'b1, 40'd0, 40'd0, 1'b0, 1'b1, 3);          drain();

        // Second start mid-multiply must be ignored.
        op("mul_12_34", 2'b10, 40'd12, 1'b0, 40'd34, 40'd408, 1'b0, 1'b0, 43);
        repeat (5) @(negedge clk);
        drive_start(2'b00, 40'd1, 1'b0, 40'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        // Abort in the 10th DIV_ITER cycle: outputs clear, no done.
        @(negedge clk);
        drive_start(2'b11, 40'd1000, 1'b0, 40'd7);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk_zero_outputs("abort_div");
        repeat (60) @(negedge clk);

        // Abort and start together: start is dropped.
        drive_start(2'b00, 40'd2, 1'b0, 40'd3);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        chk("abort_start_busy", 64'(bus.o_busy), 64'd0);
        repeat (10) @(negedge clk);

        // Reset mid-multiply after a nonzero result.
        op("add_pre_reset", 2'b00, 40'd7, 1'b1, 40'd2, 40'd5, 1'b1, 1'b0, 4); drain();
        @(negedge clk);
        drive_start(2'b10, 40'd999, 1'b1, 40'd1000);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset_mid_op");
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
